// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_pkg
//  Description : Shared JK command encoding and the load-mode command helper
//                used by the JK-based counter family.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

  // {j,k} command pair applied to one JK cell.
  typedef logic [1:0] jk_cmd_t;

  localparam jk_cmd_t JK_HOLD   = 2'b00;
  localparam jk_cmd_t JK_RESET  = 2'b01;
  localparam jk_cmd_t JK_SET    = 2'b10;
  localparam jk_cmd_t JK_TOGGLE = 2'b11;

  // Load-mode command for one bit: always drive the cell explicitly to the
  // target level, so the result does not depend on the current value even
  // when that value is corrupted. The current bit is accepted so that all
  // excitation helpers share a (current, target) signature.
  function automatic jk_cmd_t jk_load_cmd(input logic cur, input logic tgt);
    jk_cmd_t cmd;
    cmd = tgt ? JK_SET : JK_RESET;
    if (cur === tgt) begin
      cmd = tgt ? JK_SET : JK_RESET;
    end
    return cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
//  Module      : jk_cell
//  Description : Single JK flip-flop with synchronous active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/jk_sync_counter.sv
`default_nettype none
// ============================================================================
//  Module      : jk_sync_counter
//  Description : Modulo-MODULUS up/down counter built from WIDTH JK cells.
//                Computes per-bit J/K excitation from the current count and
//                the controls; exposes a cascade terminal count and a
//                registered wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   q,
  output logic               tc,
  output logic               wrap,
  output logic [2*WIDTH-1:0] jk_cmd
);

  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
    $error("jk_sync_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  // Arithmetic runs one bit wider so MODULUS = 2^WIDTH is representable.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MOD_MAX = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0]     q_ext;
  logic [WIDTH-1:0]   count_d;
  logic [WIDTH-1:0]   load_tgt;
  logic [2*WIDTH-1:0] cmd_d;
  logic               wrap_q;

  assign q_ext = {1'b0, q};

  // Count target for an enabled cycle; out-of-range values collapse to 0.
  always_comb begin
    count_d = '0;
    if (up) begin
      if (q_ext >= MOD_MAX) begin
        count_d = '0;
      end else begin
        count_d = WIDTH'(q_ext + 1'b1);
      end
    end else begin
      if (q_ext == '0) begin
        count_d = WIDTH'(MOD_MAX);
      end else if (q_ext >= MOD_EXT) begin
        count_d = '0;
      end else begin
        count_d = WIDTH'(q_ext - 1'b1);
      end
    end
  end

  // Loads beyond the sequence are replaced by 0.
  assign load_tgt = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;

  // Per-bit excitation with priority reset > load > en > idle.
  always_comb begin
    cmd_d = '0;
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd_d[2*i +: 2] = JK_RESET;
      end
    end else if (load) begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd_d[2*i +: 2] = jk_load_cmd(q[i], load_tgt[i]);
      end
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        cmd_d[2*i +: 2] = (q[i] != count_d[i]) ? JK_TOGGLE : JK_HOLD;
      end
    end
  end

  assign jk_cmd = cmd_d;

  // Terminal count feeds the enable of a cascaded stage, so it is combinational.
  assign tc = en & ~load & ~reset & (up ? (q_ext == MOD_MAX) : (q_ext == '0));

  // Wrap pulse: tc delayed by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tc;
    end
  end

  assign wrap = wrap_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (cmd_d[2*i+1]),
      .k     (cmd_d[2*i]),
      .q     (q[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_sync_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_sync_counter
//  Description : Self-checking bench for jk_sync_counter (4-bit mod-10 and
//                3-bit mod-8 instances) against a modular-arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_sync_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, MODULUS=10
  logic       reset = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q;
  logic       tc, wrap;
  logic [7:0] jk_cmd;

  // Instance B: WIDTH=3, MODULUS=8
  logic       b_reset = 1'b1, b_en = 1'b0, b_up = 1'b1, b_load = 1'b0;
  logic [2:0] b_load_val = '0;
  logic [2:0] b_q;
  logic       b_tc, b_wrap;
  logic [5:0] b_jk_cmd;

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .wrap(wrap), .jk_cmd(jk_cmd)
  );

  jk_sync_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
    .clk(clk), .reset(b_reset), .en(b_en), .up(b_up), .load(b_load),
    .load_val(b_load_val), .q(b_q), .tc(b_tc), .wrap(b_wrap), .jk_cmd(b_jk_cmd)
  );

  int checks = 0;
  int errors = 0;

  // Model state and per-step expectations/observations for instance A.
  int         m_q = 0;
  int         exp_q;
  bit         exp_tc, exp_wrap;
  logic [7:0] exp_cmd;
  logic       obs_tc;
  logic [7:0] obs_cmd;

  function automatic int mdl_next(int cur, bit r, bit ld, bit e, bit u, int lv, int modn);
    if (r) return 0;
    if (ld) return (lv < modn) ? lv : 0;
    if (e) return u ? (cur + 1) % modn : (cur + modn - 1) % modn;
    return cur;
  endfunction

  function automatic bit mdl_tc(int cur, bit r, bit ld, bit e, bit u, int modn);
    return e && !ld && !r && (u ? (cur == modn - 1) : (cur == 0));
  endfunction

  function automatic logic [7:0] mdl_cmd(int cur, bit ld, bit e, bit u, int lv, int modn, int w);
    logic [7:0] res;
    int nxt, tgt;
    res = '0;
    nxt = mdl_next(cur, 1'b0, ld, e, u, lv, modn);
    tgt = (lv < modn) ? lv : 0;
    for (int i = 0; i < w; i++) begin
      if (ld)     res[2*i +: 2] = ((tgt >> i) & 1) ? 2'b10 : 2'b01;
      else if (e) res[2*i +: 2] = (((cur ^ nxt) >> i) & 1) ? 2'b11 : 2'b00;
    end
    return res;
  endfunction

  // Drive one cycle on instance A, capture pre-edge combinational outputs,
  // and advance the model across the edge.
  task automatic step_a(input bit r, input bit ld, input bit e, input bit u, input int lv);
    @(negedge clk);
    reset = r; load = ld; en = e; up = u; load_val = lv[3:0];
    #1;
    obs_tc  = tc;
    obs_cmd = jk_cmd;
    exp_tc  = mdl_tc(m_q, r, ld, e, u, 10);
    exp_cmd = mdl_cmd(m_q, ld, e, u, lv, 10, 4);
    exp_q   = mdl_next(m_q, r, ld, e, u, lv, 10);
    @(posedge clk);
    #1;
    exp_wrap = exp_tc;
    m_q = exp_q;
  endtask

  task automatic test_reset;
    step_a(1, 0, 0, 1, 0);
    step_a(1, 1, 1, 1, 5);
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    checks++; if (obs_tc !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b want 0", obs_tc); end
  endtask

  task automatic test_count_up;
    for (int k = 0; k < 12; k++) begin
      step_a(0, 0, 1, 1, 0);
      checks++; if (q !== 4'((k + 1) % 10)) begin errors++; $display("FAIL up_q[%0d]: got %0d want %0d", k, q, (k + 1) % 10); end
      checks++; if (obs_tc !== (k == 9)) begin errors++; $display("FAIL up_tc[%0d]: got %b want %b", k, obs_tc, k == 9); end
      checks++; if (wrap !== (k == 9)) begin errors++; $display("FAIL up_wrap[%0d]: got %b want %b", k, wrap, k == 9); end
      checks++; if (obs_cmd !== exp_cmd) begin errors++; $display("FAIL up_cmd[%0d]: got %b want %b", k, obs_cmd, exp_cmd); end
    end
  endtask

  task automatic test_count_down;
    int want [3] = '{9, 8, 7};
    step_a(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step_a(0, 0, 1, 0, 0);
      checks++; if (q !== 4'(want[k])) begin errors++; $display("FAIL down_q[%0d]: got %0d want %0d", k, q, want[k]); end
      checks++; if (obs_tc !== (k == 0)) begin errors++; $display("FAIL down_tc[%0d]: got %b want %b", k, obs_tc, k == 0); end
      checks++; if (wrap !== (k == 0)) begin errors++; $display("FAIL down_wrap[%0d]: got %b want %b", k, wrap, k == 0); end
    end
  endtask

  task automatic test_load;
    step_a(0, 1, 1, 1, 7);
    checks++; if (q !== 4'd7) begin errors++; $display("FAIL load7_q: got %0d want 7", q); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load7_wrap: got %b want 0", wrap); end
    checks++; if (obs_cmd !== 8'b01_10_10_10) begin errors++; $display("FAIL load7_cmd: got %b want 01101010", obs_cmd); end
    step_a(0, 1, 1, 1, 12);
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL load12_q: got %0d want 0", q); end
    step_a(0, 1, 0, 1, 9);
    step_a(0, 1, 1, 1, 5);
    checks++; if (obs_tc !== 1'b0) begin errors++; $display("FAIL load_at_tc_tc: got %b want 0", obs_tc); end
    checks++; if (q !== 4'd5 || wrap !== 1'b0) begin errors++; $display("FAIL load_at_tc: got q=%0d wrap=%b want q=5 wrap=0", q, wrap); end
  endtask

  task automatic test_idle;
    step_a(0, 1, 0, 1, 4);
    for (int k = 0; k < 5; k++) begin
      step_a(0, 0, 0, k[0], 0);
      checks++; if (q !== 4'd4) begin errors++; $display("FAIL idle_q[%0d]: got %0d want 4", k, q); end
      checks++; if (obs_cmd !== 8'h00) begin errors++; $display("FAIL idle_cmd[%0d]: got %b want 0", k, obs_cmd); end
      checks++; if (obs_tc !== 1'b0) begin errors++; $display("FAIL idle_tc[%0d]: got %b want 0", k, obs_tc); end
    end
    step_a(1, 1, 1, 1, 3);
    checks++; if (q !== 4'd0 || wrap !== 1'b0) begin errors++; $display("FAIL reset_over_load: got q=%0d wrap=%b want 0/0", q, wrap); end
  endtask

  task automatic test_dir_change;
    bit dirs [8] = '{1, 1, 0, 1, 0, 0, 0, 1};
    for (int k = 0; k < 8; k++) begin
      step_a(0, 0, 1, dirs[k], 0);
      checks++; if (q !== 4'(exp_q)) begin errors++; $display("FAIL dir_q[%0d]: got %0d want %0d", k, q, exp_q); end
      checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL dir_wrap[%0d]: got %b want %b", k, wrap, exp_wrap); end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 300; k++) begin
      bit r, ld, e, u;
      int lv;
      r  = ($urandom_range(99) < 3);
      ld = ($urandom_range(99) < 10);
      e  = ($urandom_range(99) < 75);
      u  = $urandom_range(1);
      lv = $urandom_range(15);
      step_a(r, ld, e, u, lv);
      checks++; if (q !== 4'(exp_q)) begin errors++; $display("FAIL rnd_q[%0d]: got %0d want %0d", k, q, exp_q); end
      checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL rnd_wrap[%0d]: got %b want %b", k, wrap, exp_wrap); end
      checks++; if (obs_tc !== exp_tc) begin errors++; $display("FAIL rnd_tc[%0d]: got %b want %b", k, obs_tc, exp_tc); end
      if (!r) begin
        checks++; if (obs_cmd !== exp_cmd) begin errors++; $display("FAIL rnd_cmd[%0d]: got %b want %b", k, obs_cmd, exp_cmd); end
      end
    end
  endtask

  task automatic test_pow2;
    @(negedge clk); b_reset = 1; b_load = 0; b_en = 0; b_up = 1;
    @(posedge clk); #1;
    checks++; if (b_q !== 3'd0) begin errors++; $display("FAIL p2_reset_q: got %0d want 0", b_q); end
    @(negedge clk); b_reset = 0; b_load = 1; b_load_val = 3'd7;
    @(posedge clk); #1;
    checks++; if (b_q !== 3'd7) begin errors++; $display("FAIL p2_load_q: got %0d want 7", b_q); end
    @(negedge clk); b_load = 0; b_en = 1; b_up = 1;
    #1;
    checks++; if (b_jk_cmd !== 6'b111111) begin errors++; $display("FAIL p2_cmd: got %b want 111111", b_jk_cmd); end
    checks++; if (b_tc !== 1'b1) begin errors++; $display("FAIL p2_tc: got %b want 1", b_tc); end
    @(posedge clk); #1;
    checks++; if (b_q !== 3'd0 || b_wrap !== 1'b1) begin errors++; $display("FAIL p2_wrap: got q=%0d wrap=%b want q=0 wrap=1", b_q, b_wrap); end
    @(negedge clk);
    #1;
    checks++; if (b_tc !== 1'b0) begin errors++; $display("FAIL p2_tc_after: got %b want 0", b_tc); end
    @(posedge clk); #1;
    checks++; if (b_q !== 3'd1 || b_wrap !== 1'b0) begin errors++; $display("FAIL p2_after: got q=%0d wrap=%b want q=1 wrap=0", b_q, b_wrap); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_idle();
    test_dir_change();
    test_random();
    test_pow2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jk_sync_counter.md
# jk_sync_counter

Parameterised synchronous modulo-N up/down counter built from a bank of JK flip-flop cells. The block is the excitation stage that sits directly upstream of the JK cells. It computes a per-bit J/K command (hold / reset / set / toggle) from the current count and the control inputs, then applies it to one JK cell per bit. It provides the counting/dividing function for the team's JK-based sequential designs and exposes a terminal-count flag for cascading.

## Interface
- WIDTH, 4, count width in bits; legal range 1..16.
- MODULUS, 10, count sequence is 0..MODULUS-1; legal range 2..2^WIDTH. Elaboration error if out of range.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clock clk.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load request.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count (JK cell outputs).
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse after a wrap-around.
- jk_cmd  output  2*WIDTH  current per-bit {j,k} commands, for debug. Bit i is at [2i+1:2i].

## Operation
- Per-bit commands are HOLD=00, RESET=01, SET=10, TOGGLE=11. Every q change is produced only by these commands; q is never assigned directly.
- Priority per clock: reset > load > en > idle.
- reset: all cells cleared; q=0, wrap=0.
- load:
  - Bit i gets SET if the target bit is 1, else RESET.
  - Target is load_val if load_val < MODULUS, else 0.
  - en and up are ignored in a load cycle.
  - wrap is 0 after a load.
- en, up=1:
  - next = (q == MODULUS-1) ? 0 : q+1.
  - Bit i gets TOGGLE where q[i] != next[i], HOLD elsewhere.
- en, up=0:
  - next = (q == 0) ? MODULUS-1 : q-1.
  - Bits use the same TOGGLE/HOLD rule.
- Idle (no en, no load): all bits HOLD.
- Width rule: next-state arithmetic is done at WIDTH+1 bits and compared before truncation. When MODULUS = 2^WIDTH, the wrap equals natural overflow.
- tc = en & ~load & ~reset & (up ? q == MODULUS-1 : q == 0).
- wrap is registered tc: it is high for exactly one cycle after each wrap-around.
- Out-of-range q: q ≥ MODULUS can only arise from X/reset corruption. With en=1 it goes to 0 on the next edge in either direction.

## Timing
- Latency is one cycle. Inputs sampled at edge n are reflected on q after edge n.
- tc is combinational from q, en, up, load and reset. It is valid in the same cycle and intended as the en input of a following cascaded stage.
- wrap is asserted in cycle n+1 when tc was high at edge n.
- jk_cmd is combinational and shows the command applied at the next edge.
- Reset mid-count: q=0 and wrap=0 after the edge, regardless of load or en. tc is forced 0 while reset is high.
- Simultaneous load and en: load wins, and no wrap is generated.
- Direction change while enabled takes effect on the next edge with no dead cycle.

## Structure
- Package jk_pkg holds:
  - the 2-bit jk_cmd_t typedef;
  - constants JK_HOLD, JK_RESET, JK_SET, JK_TOGGLE;
  - a helper function that returns the command for a (current, target) bit pair in load mode.
- Sub-module jk_cell: a single JK flip-flop with synchronous active-high reset, ports clk, reset, j, k, q.
  - Instantiated WIDTH times through a generate loop.
- The top level contains only next-state/command logic, tc, and the wrap register.

## Test plan
- Reset release, WIDTH=4, MODULUS=10, en=1, up=1 for 12 cycles → q = 0,1,…,9,0,1. tc is high while q=9; wrap is high for one cycle with q=0.
- up=0 from q=0, en=1 → q = 9,8,7. tc is high in the q=0 cycle; wrap pulses with q=9.
- load=1 with load_val=7 and en=1 in the same cycle → q=7, no wrap. Then load_val=12 (≥ MODULUS) → q=0.
- en=0 for 5 cycles at q=4 → q holds 4, jk_cmd is all 00, tc=0. Then reset asserted together with load=1, load_val=3 → q=0.
- WIDTH=3, MODULUS=8 counting up from q=7 → q=0. jk_cmd shows TOGGLE on all three bits; wrap pulses once.
